pc_unit: RTL and testbench

Parametrised program-counter unit for the RISC core's fetch stage. It holds the architectural PC and updates it each enabled cycle according to an opcode: increment, skip, relative branch forward or backward, absolute jump, call and return. Calls and returns use an internal hardware return-address stack. It generalises the earlier combinational PC add/subtract helper with a registered PC, configurable width, a call stack, wrap detection and fault reporting.

---
 rtl/pc_unit.sv | 166 ++++++++++++++++
 tb/tb_pc_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: registered program counter for the fetch stage.
//
// Each enabled cycle the PC is updated from a 3-bit opcode: hold, increment,
// skip (+2), relative branch (add/subtract val), absolute jump, call and
// return. Calls push PC+1 onto a small internal return-address stack.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset, dominates every other input
//   en           advance strobe; 0 holds all state and clears wrap
//   op[2:0]      operation select (sampled when en=1)
//   val[W-1:0]   branch offset (REL) or target address (JMP, CALL)
//   as           REL direction: 0 = add, 1 = subtract
//   pc[W-1:0]    current PC
//   sp           number of occupied stack entries
//   stack_full   sp == STACK_DEPTH
//   stack_empty  sp == 0
//   fault        sticky stack overflow/underflow flag
//   wrap         one-cycle flag: last INC/SKIP/REL left the 0..2^W-1 range
module pc_unit #(
  parameter int          WIDTH       = 8,
  parameter int          STACK_DEPTH = 4,
  parameter int unsigned RESET_VEC   = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [2:0]                       op,
  input  logic [WIDTH-1:0]                 val,
  input  logic                             as,
  output logic [WIDTH-1:0]                 pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
  output logic                             stack_full,
  output logic                             stack_empty,
  output logic                             fault,
  output logic                             wrap
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  // Entry index width; at least one bit so a depth-1 stack still has an index.
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [WIDTH:0] EXT_ONE = WIDTH'(1);
  localparam logic [WIDTH:0] EXT_TWO = WIDTH'(2);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_INC  = 3'b001,
    OP_REL  = 3'b010,
    OP_JMP  = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101,
    OP_SKIP = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             fault_q, fault_d;
  logic             wrap_q, wrap_d;
  logic             push_en;
  logic [WIDTH:0]   ext_sum;
  logic [IW-1:0]    push_idx;
  logic [IW-1:0]    pop_idx;
  logic             full_w;
  logic             empty_w;

  // Small register-file stack: RET must see the top entry in the same cycle
  // (including one pushed on the previous edge), so reads are asynchronous.
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];

  assign full_w   = (sp_q == SPW'(STACK_DEPTH));
  assign empty_w  = (sp_q == '0);
  // sp counts entries, so the free slot is sp and the top is sp-1. Taking the
  // low IW bits first keeps the index in range for power-of-two depths.
  assign push_idx = sp_q[IW-1:0];
  assign pop_idx  = push_idx - IW'(1);

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    fault_d = fault_q;
    wrap_d  = 1'b0;
    push_en = 1'b0;
    ext_sum = '0;
    if (en) begin
      unique case (op_e'(op))
        OP_INC: begin
          ext_sum = {1'b0, pc_q} + EXT_ONE;
          pc_d    = ext_sum[WIDTH-1:0];
          wrap_d  = ext_sum[WIDTH];
        end
        OP_SKIP: begin
          ext_sum = {1'b0, pc_q} + EXT_TWO;
          pc_d    = ext_sum[WIDTH-1:0];
          wrap_d  = ext_sum[WIDTH];
        end
        OP_REL: begin
          // The extra top bit is the carry on add and the borrow on subtract.
          ext_sum = as ? ({1'b0, pc_q} - {1'b0, val})
                       : ({1'b0, pc_q} + {1'b0, val});
          pc_d    = ext_sum[WIDTH-1:0];
          wrap_d  = ext_sum[WIDTH];
        end
        OP_JMP: begin
          pc_d = val;
        end
        OP_CALL: begin
          if (full_w) begin
            fault_d = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SPW'(1);
            pc_d    = val;
          end
        end
        OP_RET: begin
          if (empty_w) begin
            fault_d = 1'b1;
          end else begin
            sp_d = sp_q - SPW'(1);
            pc_d = stack_q[pop_idx];
          end
        end
        OP_HOLD, OP_RSVD: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= WIDTH'(RESET_VEC);
      sp_q    <= '0;
      fault_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      fault_q <= fault_d;
      wrap_q  <= wrap_d;
    end
  end

  // Stack entries are never reset; sp=0 makes stale contents unreachable.
  genvar gi;
  generate
    for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
      always_ff @(posedge clk) begin
        if (!rst && push_en && (push_idx == IW'(gi))) begin
          stack_q[gi] <= pc_q + WIDTH'(1);
        end
      end
    end
  endgenerate

  assign pc          = pc_q;
  assign sp          = sp_q;
  assign stack_full  = full_w;
  assign stack_empty = empty_w;
  assign fault       = fault_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit (WIDTH=8, STACK_DEPTH=4, RESET_VEC=0): directed
// scenarios followed by randomized traffic, all checked against a
// queue-based reference model using plain integer arithmetic.
module tb_pc_unit;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int RV = 0;
  localparam int PC_MAX = (1 << W) - 1;

  localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, REL = 3'd2, JMP = 3'd3,
                         CALL = 3'd4, RET = 3'd5, SKIP = 3'd6, RSVD = 3'd7;

  logic         clk = 1'b0;
  logic         rst, en, as_r;
  logic [2:0]   op;
  logic [W-1:0] val;
  logic [W-1:0] pc;
  logic [2:0]   sp;
  logic         stack_full, stack_empty, fault, wrap;

  pc_unit #(.WIDTH(W), .STACK_DEPTH(D), .RESET_VEC(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .val(val), .as(as_r),
    .pc(pc), .sp(sp), .stack_full(stack_full), .stack_empty(stack_empty),
    .fault(fault), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_pc;
  int m_stk[$];
  bit m_fault;
  bit m_wrap;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input int o,
                            input int v, input bit a);
    int t;
    if (r) begin
      m_pc = RV;
      m_stk.delete();
      m_fault = 1'b0;
      m_wrap = 1'b0;
      return;
    end
    m_wrap = 1'b0;
    if (!e) return;
    case (o)
      1, 2, 6: begin
        if (o == 1)      t = m_pc + 1;
        else if (o == 6) t = m_pc + 2;
        else             t = a ? (m_pc - v) : (m_pc + v);
        m_wrap = (t < 0) || (t > PC_MAX);
        m_pc   = t & PC_MAX;
      end
      3: m_pc = v;
      4: begin
        if (m_stk.size() == D) m_fault = 1'b1;
        else begin
          m_stk.push_back((m_pc + 1) & PC_MAX);
          m_pc = v;
        end
      end
      5: begin
        if (m_stk.size() == 0) m_fault = 1'b1;
        else m_pc = m_stk.pop_back();
      end
      default: ;
    endcase
  endtask

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic cyc(input bit r, input bit e, input logic [2:0] o,
                     input logic [W-1:0] v, input bit a);
    rst = r; en = e; op = o; val = v; as_r = a;
    @(posedge clk);
    model_step(r, e, int'(o), int'(v), a);
    #1;
    $display("[TB] t=%0t rst=%0b en=%0b op=%0d val=%02h as=%0b -> pc=%02h sp=%0d full=%0b empty=%0b fault=%0b wrap=%0b",
             $time, r, e, o, v, a, pc, sp, stack_full, stack_empty, fault, wrap);
    check_val("pc", pc, m_pc);
    check_val("sp", sp, m_stk.size());
    check_val("stack_full", stack_full, m_stk.size() == D);
    check_val("stack_empty", stack_empty, m_stk.size() == 0);
    check_val("fault", fault, m_fault);
    check_val("wrap", wrap, m_wrap);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; op = HOLD; val = '0; as_r = 1'b0;

    // Reset dominates an enabled INC
    cyc(1, 1, INC, 8'h00, 0);
    check_val("rst_pc", pc, 8'h00);
    check_val("rst_empty", stack_empty, 1'b1);

    // INC x3
    cyc(0, 1, INC, 8'h00, 0);
    cyc(0, 1, INC, 8'h00, 0);
    cyc(0, 1, INC, 8'h00, 0);
    check_val("inc3_pc", pc, 8'h03);

    // Increment wrap and skip wrap
    cyc(0, 1, JMP, 8'hFE, 0);
    cyc(0, 1, INC, 8'h00, 0);
    check_val("inc_ff_wrap", wrap, 1'b0);
    cyc(0, 1, INC, 8'h00, 0);
    check_val("inc_wrap_pc", pc, 8'h00);
    check_val("inc_wrap", wrap, 1'b1);
    cyc(0, 1, JMP, 8'hFF, 0);
    cyc(0, 1, SKIP, 8'h00, 0);
    check_val("skip_wrap_pc", pc, 8'h01);
    check_val("skip_wrap", wrap, 1'b1);

    // Relative branches and en=0 hold
    cyc(0, 1, JMP, 8'h03, 0);
    cyc(0, 1, REL, 8'h05, 1);
    check_val("rel_sub_pc", pc, 8'hFE);
    check_val("rel_sub_wrap", wrap, 1'b1);
    cyc(0, 1, JMP, 8'h20, 0);
    cyc(0, 1, REL, 8'h10, 0);
    check_val("rel_add_pc", pc, 8'h30);
    cyc(0, 0, INC, 8'h00, 0);
    cyc(0, 0, INC, 8'h00, 0);
    check_val("en0_pc", pc, 8'h30);

    // Nested call/return
    cyc(0, 1, JMP, 8'h10, 0);
    cyc(0, 1, CALL, 8'h40, 0);
    cyc(0, 1, CALL, 8'h80, 0);
    check_val("call2_sp", sp, 3'd2);
    cyc(0, 1, RET, 8'h00, 0);
    check_val("ret1_pc", pc, 8'h41);
    cyc(0, 1, RET, 8'h00, 0);
    check_val("ret2_pc", pc, 8'h11);
    check_val("ret2_fault", fault, 1'b0);

    // Overflow then underflow
    for (int i = 0; i < D; i++) cyc(0, 1, CALL, 8'(8'h20 + i), 0);
    check_val("full_flag", stack_full, 1'b1);
    cyc(0, 1, CALL, 8'h99, 0);
    check_val("ovf_pc", pc, 8'h23);
    check_val("ovf_fault", fault, 1'b1);
    for (int i = 0; i < D; i++) cyc(0, 1, RET, 8'h00, 0);
    cyc(0, 1, RET, 8'h00, 0);
    check_val("udf_pc", pc, 8'h12);
    check_val("udf_sp", sp, 3'd0);

    // Reset in the middle of a call sequence
    for (int i = 0; i < 3; i++) cyc(0, 1, CALL, 8'(8'h50 + i), 0);
    cyc(1, 1, CALL, 8'h55, 0);
    check_val("mid_rst_pc", pc, 8'h00);
    check_val("mid_rst_fault", fault, 1'b0);
    cyc(0, 1, RET, 8'h00, 0);
    check_val("post_rst_ret_fault", fault, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
          3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
